// File: rtl/inst_mem_fetch.sv
// Synchronous-read instruction memory with a valid/ready fetch port, a one-entry
// in-flight read stage, a FIFO_DEPTH response buffer, fault reporting and a word-load port.
module inst_mem_fetch #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INST_WIDTH  = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int FIFO_DEPTH  = 2,
  parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [INST_WIDTH-1:0] resp_inst,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [1:0]            resp_fault,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [INST_WIDTH-1:0] load_data
);

  localparam int MIDX_W = $clog2(DEPTH_BYTES);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);
  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_OOR = 2'b10;

  // Handshakes: a fetch transfers on the edge where req_valid & req_ready, a response
  // is consumed on the edge where resp_valid & resp_ready; payload is held while stalled.

  logic [7:0] mem_q [DEPTH_BYTES];

  logic [ADDR_WIDTH-1:0] load_word;
  logic [MIDX_W-1:0]     load_idx;
  logic                  load_we;
  logic                  load_unused;

  assign load_word   = {load_addr[ADDR_WIDTH-1:2], 2'b00};
  assign load_we     = load_en && (load_word <= LAST_WORD);
  assign load_idx    = load_word[MIDX_W-1:0];
  assign load_unused = ^load_addr[1:0];

  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[load_idx]               <= load_data[7:0];
      mem_q[load_idx + MIDX_W'(1)] <= load_data[15:8];
      mem_q[load_idx + MIDX_W'(2)] <= load_data[23:16];
      mem_q[load_idx + MIDX_W'(3)] <= load_data[31:24];
    end
  end

  logic                  req_fire;
  logic                  fetch_mis;
  logic                  fetch_oor;
  logic [1:0]            fetch_fault;
  logic [MIDX_W-1:0]     fetch_idx;
  logic [INST_WIDTH-1:0] fetch_word;
  logic [INST_WIDTH-1:0] fetch_inst;

  // Range check runs at full address width so huge addresses cannot alias into memory.
  assign fetch_mis   = |req_addr[1:0];
  assign fetch_oor   = req_addr > LAST_WORD;
  assign fetch_fault = fetch_mis ? F_MIS : (fetch_oor ? F_OOR : F_OK);
  assign fetch_idx   = req_addr[MIDX_W-1:0];
  assign fetch_word  = {mem_q[fetch_idx + MIDX_W'(3)], mem_q[fetch_idx + MIDX_W'(2)],
                        mem_q[fetch_idx + MIDX_W'(1)], mem_q[fetch_idx]};
  assign fetch_inst  = (fetch_fault == F_OK) ? fetch_word : NOP_INST;

  logic                  infl_valid_q, infl_valid_d;
  logic [INST_WIDTH-1:0] infl_inst_q,  infl_inst_d;
  logic [ADDR_WIDTH-1:0] infl_addr_q,  infl_addr_d;
  logic [1:0]            infl_fault_q, infl_fault_d;

  logic [INST_WIDTH-1:0] fifo_inst_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [1:0]            fifo_fault_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        count_w;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign resp_valid = (occ_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign push       = infl_valid_q && !flush;
  assign count_w    = {1'b0, occ_q} + (CNT_W+1)'(infl_valid_q) - (CNT_W+1)'(pop);
  assign req_ready  = !reset && !load_en && !flush && (count_w < (CNT_W+1)'(FIFO_DEPTH));
  assign req_fire   = req_valid && req_ready;

  assign resp_inst  = resp_valid ? fifo_inst_q[rd_ptr_q]  : '0;
  assign resp_addr  = resp_valid ? fifo_addr_q[rd_ptr_q]  : '0;
  assign resp_fault = resp_valid ? fifo_fault_q[rd_ptr_q] : '0;

  always_comb begin
    infl_valid_d = req_fire;
    infl_inst_d  = infl_inst_q;
    infl_addr_d  = infl_addr_q;
    infl_fault_d = infl_fault_q;
    if (req_fire) begin
      infl_inst_d  = fetch_inst;
      infl_addr_d  = req_addr;
      infl_fault_d = fetch_fault;
    end
  end

  // Flush wins over any pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q]  <= infl_inst_q;
      fifo_addr_q[wr_ptr_q]  <= infl_addr_q;
      fifo_fault_q[wr_ptr_q] <= infl_fault_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      infl_valid_q <= 1'b0;
      infl_inst_q  <= '0;
      infl_addr_q  <= '0;
      infl_fault_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
    end else begin
      infl_valid_q <= infl_valid_d;
      infl_inst_q  <= infl_inst_d;
      infl_addr_q  <= infl_addr_d;
      infl_fault_q <= infl_fault_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
    end
  end

endmodule
